// File: rtl/router_pkt_tx_if.sv
// Handshake and byte bus between a packet source and the router packet transmitter.
// The slave modport is the transmitter's view; the master modport is the driver's view.
interface router_pkt_tx_if;
  logic       start;
  logic [1:0] addr;
  logic [5:0] payload_len;
  logic       corrupt_parity;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pl_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_busy;
  logic       done;
  logic       err_req;

  modport master (
    output start, addr, payload_len, corrupt_parity, pl_valid, pl_data, busy,
    input  pl_ready, data_out, pkt_valid, tx_busy, done, err_req
  );

  modport slave (
    input  start, addr, payload_len, corrupt_parity, pl_valid, pl_data, busy,
    output pl_ready, data_out, pkt_valid, tx_busy, done, err_req
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Buffers a payload, then streams header, payload and parity bytes to the router,
// holding the current byte while the router stalls; all outputs are registered.
module router_pkt_tx #(
  parameter int GAP_CYCLES = 2
) (
  input logic            clock,
  input logic            resetn,
  router_pkt_tx_if.slave bus
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3,
    PARITY  = 3'd4,
    GAP     = 3'd5
  } state_t;

  function automatic logic [7:0] header_byte(input logic [5:0] len, input logic [1:0] dst);
    return {len, dst};
  endfunction

  state_t        state_r, state_s;
  logic [1:0]    addr_r, addr_s;
  logic [5:0]    len_r, len_s;
  logic          corrupt_r, corrupt_s;
  logic [5:0]    wr_cnt_r, wr_cnt_s;
  logic [5:0]    rd_cnt_r, rd_cnt_s;
  logic [7:0]    parity_r, parity_s;
  logic [GW-1:0] gap_cnt_r, gap_cnt_s;
  logic [7:0]    data_out_r, data_out_s;
  logic          pkt_valid_r, pkt_valid_s;
  logic          pl_ready_r, pl_ready_s;
  logic          tx_busy_r, tx_busy_s;
  logic          done_r, done_s;
  logic          err_req_r, err_req_s;
  logic          buf_we_s;
  logic          accept_s;
  logic [7:0]    pay_buf_r [0:63];

  assign accept_s = bus.pl_valid & pl_ready_r;

  // State, counters and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      addr_r      <= 2'd0;
      len_r       <= 6'd0;
      corrupt_r   <= 1'b0;
      wr_cnt_r    <= 6'd0;
      rd_cnt_r    <= 6'd0;
      parity_r    <= 8'd0;
      gap_cnt_r   <= '0;
      data_out_r  <= 8'd0;
      pkt_valid_r <= 1'b0;
      pl_ready_r  <= 1'b0;
      tx_busy_r   <= 1'b0;
      done_r      <= 1'b0;
      err_req_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      len_r       <= len_s;
      corrupt_r   <= corrupt_s;
      wr_cnt_r    <= wr_cnt_s;
      rd_cnt_r    <= rd_cnt_s;
      parity_r    <= parity_s;
      gap_cnt_r   <= gap_cnt_s;
      data_out_r  <= data_out_s;
      pkt_valid_r <= pkt_valid_s;
      pl_ready_r  <= pl_ready_s;
      tx_busy_r   <= tx_busy_s;
      done_r      <= done_s;
      err_req_r   <= err_req_s;
    end
  end

  // Payload buffer write port (contents need no reset)
  always_ff @(posedge clock) begin
    if (buf_we_s) begin
      pay_buf_r[wr_cnt_r] <= bus.pl_data;
    end
  end

  // Next-state, counter and next-output logic
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    len_s     = len_r;
    corrupt_s = corrupt_r;
    wr_cnt_s  = wr_cnt_r;
    rd_cnt_s  = rd_cnt_r;
    parity_s  = parity_r;
    gap_cnt_s = gap_cnt_r;
    done_s    = 1'b0;
    err_req_s = 1'b0;
    buf_we_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if ((bus.payload_len == 6'd0) || (bus.addr == 2'd3)) begin
            err_req_s = 1'b1;
          end else begin
            state_s   = LOAD;
            addr_s    = bus.addr;
            len_s     = bus.payload_len;
            corrupt_s = bus.corrupt_parity;
            parity_s  = header_byte(bus.payload_len, bus.addr);
            wr_cnt_s  = 6'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          buf_we_s = 1'b1;
          parity_s = parity_r ^ bus.pl_data;
          wr_cnt_s = wr_cnt_r + 6'd1;
          if (wr_cnt_r == (len_r - 6'd1)) begin
            state_s = HEADER;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      HEADER: begin
        if (!bus.busy) begin
          state_s  = PAYLOAD;
          rd_cnt_s = 6'd0;
        end else begin
          state_s = HEADER;
        end
      end
      PAYLOAD: begin
        if (!bus.busy) begin
          if (rd_cnt_r == (len_r - 6'd1)) begin
            state_s = PARITY;
          end else begin
            rd_cnt_s = rd_cnt_r + 6'd1;
          end
        end else begin
          state_s = PAYLOAD;
        end
      end
      PARITY: begin
        if (!bus.busy) begin
          done_s    = 1'b1;
          gap_cnt_s = '0;
          state_s   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          state_s = PARITY;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Outputs are derived from the upcoming state so a stall re-selects the same byte
    data_out_s  = 8'd0;
    pkt_valid_s = 1'b0;
    case (state_s)
      HEADER: begin
        data_out_s  = header_byte(len_s, addr_s);
        pkt_valid_s = 1'b1;
      end
      PAYLOAD: begin
        data_out_s  = pay_buf_r[rd_cnt_s];
        pkt_valid_s = 1'b1;
      end
      PARITY: begin
        data_out_s  = parity_s ^ {8{corrupt_s}};
        pkt_valid_s = 1'b0;
      end
      default: begin
        data_out_s  = 8'd0;
        pkt_valid_s = 1'b0;
      end
    endcase
    pl_ready_s = (state_s == LOAD);
    tx_busy_s  = (state_s != IDLE);
  end

  assign bus.data_out  = data_out_r;
  assign bus.pkt_valid = pkt_valid_r;
  assign bus.pl_ready  = pl_ready_r;
  assign bus.tx_busy   = tx_busy_r;
  assign bus.done      = done_r;
  assign bus.err_req   = err_req_r;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: nominal packet, stalls, corrupt parity,
// illegal requests, mid-packet reset and a full-depth packet with ragged pl_valid.
module tb_router_pkt_tx;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] pay [0:63];

  always #5 clock = ~clock;

  router_pkt_tx_if bus();

  router_pkt_tx #(.GAP_CYCLES(2)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [1:0] a, input logic [5:0] len, input logic corr);
    bus.start          = 1'b1;
    bus.addr           = a;
    bus.payload_len    = len;
    bus.corrupt_parity = corr;
    tick();
    bus.start          = 1'b0;
    bus.corrupt_parity = 1'b0;
  endtask

  // Feeds len bytes; start (with other fields) and busy are waved to show they are ignored
  task automatic do_load(input int len, input bit rnd);
    int   acc = 0;
    int   cyc = 0;
    logic rdy;
    while (acc < len && cyc < 2000) begin
      bus.pl_valid    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pl_data     = pay[acc];
      bus.start       = 1'b1;
      bus.addr        = 2'd0;
      bus.payload_len = 6'd1;
      bus.busy        = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      rdy             = bus.pl_ready;
      tick();
      if (bus.pl_valid && rdy) acc++;
      cyc++;
    end
    bus.pl_valid = 1'b0;
    bus.start    = 1'b0;
    bus.busy     = 1'b0;
    chk("load_count", 8'(acc), 8'(len));
  endtask

  task automatic do_stream(input logic [1:0] a, input logic [5:0] len, input logic corr,
                           input int stall_at, input int stall_n);
    logic [7:0] hdr;
    logic [7:0] par;
    hdr = {len, a};
    par = hdr;
    for (int i = 0; i < int'(len); i++) par = par ^ pay[i];
    if (corr) par = ~par;
    chk("hdr_data", bus.data_out, hdr);
    chk("hdr_valid", 8'(bus.pkt_valid), 8'd1);
    chk("hdr_pl_ready", 8'(bus.pl_ready), 8'd0);
    chk("hdr_tx_busy", 8'(bus.tx_busy), 8'd1);
    for (int i = 0; i < int'(len); i++) begin
      tick();
      chk("pay_data", bus.data_out, pay[i]);
      chk("pay_valid", 8'(bus.pkt_valid), 8'd1);
      if (i == stall_at) begin
        bus.busy = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk("stall_data", bus.data_out, pay[i]);
          chk("stall_valid", 8'(bus.pkt_valid), 8'd1);
        end
        bus.busy = 1'b0;
      end
    end
    tick();
    chk("par_data", bus.data_out, par);
    chk("par_valid", 8'(bus.pkt_valid), 8'd0);
    chk("par_done_early", 8'(bus.done), 8'd0);
    tick();
    chk("done_pulse", 8'(bus.done), 8'd1);
    chk("gap1_data", bus.data_out, 8'd0);
    chk("gap1_valid", 8'(bus.pkt_valid), 8'd0);
    chk("gap1_tx_busy", 8'(bus.tx_busy), 8'd1);
    tick();
    chk("gap2_done", 8'(bus.done), 8'd0);
    chk("gap2_tx_busy", 8'(bus.tx_busy), 8'd1);
    tick();
    chk("idle_tx_busy", 8'(bus.tx_busy), 8'd0);
    chk("idle_done", 8'(bus.done), 8'd0);
  endtask

  initial begin
    bus.start          = 1'b0;
    bus.addr           = 2'd0;
    bus.payload_len    = 6'd0;
    bus.corrupt_parity = 1'b0;
    bus.pl_valid       = 1'b0;
    bus.pl_data        = 8'd0;
    bus.busy           = 1'b0;
    for (int i = 0; i < 64; i++) pay[i] = 8'd0;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44; pay[4] = 8'h55;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_data", bus.data_out, 8'd0);
    chk("rst_valid", 8'(bus.pkt_valid), 8'd0);
    chk("rst_pl_ready", 8'(bus.pl_ready), 8'd0);
    chk("rst_tx_busy", 8'(bus.tx_busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_err", 8'(bus.err_req), 8'd0);
    resetn = 1'b1;
    tick();

    // Nominal len=5 addr=2: 16 11 22 33 44 55, parity 07
    do_start(2'd2, 6'd5, 1'b0);
    chk("load_pl_ready", 8'(bus.pl_ready), 8'd1);
    chk("load_tx_busy", 8'(bus.tx_busy), 8'd1);
    chk("load_valid", 8'(bus.pkt_valid), 8'd0);
    do_load(5, 1'b0);
    chk("hdr_literal", bus.data_out, 8'h16);
    do_stream(2'd2, 6'd5, 1'b0, -1, 0);

    // Router stall for 3 cycles on byte 22
    do_start(2'd2, 6'd5, 1'b0);
    do_load(5, 1'b0);
    do_stream(2'd2, 6'd5, 1'b0, 1, 3);

    // Corrupt parity: F8
    do_start(2'd2, 6'd5, 1'b1);
    do_load(5, 1'b0);
    do_stream(2'd2, 6'd5, 1'b1, -1, 0);

    // Illegal requests: len=0, then addr=3
    bus.start = 1'b1; bus.addr = 2'd1; bus.payload_len = 6'd0;
    tick();
    bus.start = 1'b0;
    chk("err_len0", 8'(bus.err_req), 8'd1);
    chk("err_len0_tx_busy", 8'(bus.tx_busy), 8'd0);
    chk("err_len0_valid", 8'(bus.pkt_valid), 8'd0);
    tick();
    chk("err_len0_pulse_end", 8'(bus.err_req), 8'd0);
    bus.start = 1'b1; bus.addr = 2'd3; bus.payload_len = 6'd4;
    tick();
    bus.start = 1'b0;
    chk("err_addr3", 8'(bus.err_req), 8'd1);
    chk("err_addr3_tx_busy", 8'(bus.tx_busy), 8'd0);
    chk("err_addr3_pl_ready", 8'(bus.pl_ready), 8'd0);
    tick();
    chk("err_addr3_pulse_end", 8'(bus.err_req), 8'd0);
    chk("err_addr3_valid", 8'(bus.pkt_valid), 8'd0);

    // Reset while payload byte 3 (33) is on the bus
    do_start(2'd2, 6'd5, 1'b0);
    do_load(5, 1'b0);
    tick();
    tick();
    tick();
    chk("pre_rst_data", bus.data_out, 8'h33);
    resetn = 1'b0;
    #1;
    chk("mid_rst_data", bus.data_out, 8'd0);
    chk("mid_rst_valid", 8'(bus.pkt_valid), 8'd0);
    chk("mid_rst_tx_busy", 8'(bus.tx_busy), 8'd0);
    chk("mid_rst_pl_ready", 8'(bus.pl_ready), 8'd0);
    #2;
    resetn = 1'b1;
    tick();
    chk("post_rst_tx_busy", 8'(bus.tx_busy), 8'd0);
    pay[0] = 8'hA5;
    do_start(2'd1, 6'd1, 1'b0);
    do_load(1, 1'b0);
    chk("len1_hdr_literal", bus.data_out, 8'h05);
    do_stream(2'd1, 6'd1, 1'b0, -1, 0);

    // Full depth: len=63, payload 00..3E, ragged pl_valid
    for (int i = 0; i < 63; i++) pay[i] = 8'(i);
    do_start(2'd0, 6'd63, 1'b0);
    do_load(63, 1'b1);
    do_stream(2'd0, 6'd63, 1'b0, 30, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
